// File: rtl/ysyx_25040109_pkg.sv
// Shared constants for the ysyx_25040109 core slice.
package ysyx_25040109_pkg;

  // Architectural register / PC width.
  localparam int XLEN = 32;

  // Default number of entries in the fetch queue.
  localparam int IFQ_DEPTH_DEFAULT = 4;

  // Width of one stored fetch entry: {pc, inst}.
  function automatic int ifq_entry_w(input int data_w);
    return data_w + XLEN;
  endfunction

endpackage

// File: rtl/ysyx_25040109_fifo_ram.sv
// Storage array for the fetch queue: one write port, one asynchronous
// read port, and no reset on the contents.
module ysyx_25040109_fifo_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_25040109_ifu_queue.sv
// Instruction fetch queue between instruction memory and the decoder.
// A circular buffer of {pc, inst} pairs with optional zero-latency
// pass-through while empty, and a flush for branch redirects.
//
// Handshake: a transfer on either side happens in a cycle where both
// valid and ready are high at the rising edge (mem_fire / idu_fire).
// Producers may not depend on ready to raise valid; while valid is high
// with a stored entry, the presented {pc, inst} stays stable until it is
// taken or flushed.
module ysyx_25040109_ifu_queue
  import ysyx_25040109_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int DEPTH  = IFQ_DEPTH_DEFAULT,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      imem_rdata,
  input  logic [31:0]            imem_pc,
  input  logic                   mem_valid,
  output logic                   ifu_ready_to_mem,
  input  logic                   idu_ready,
  output logic [DATA_W-1:0]      inst_ifu,
  output logic [31:0]            pc_ifu,
  output logic                   ifu_valid_to_idu,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ifq_entry_w(DATA_W);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] rd_entry;
  logic          empty;
  logic          full;
  logic          mem_fire;
  logic          idu_fire;
  logic          bypass_fire;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // Reset and flush both silence the handshakes in the same cycle.
  // Accepting while full is only possible because the head leaves in
  // that same cycle (idu_ready with a non-empty queue means idu_fire).
  assign ifu_ready_to_mem = !rst && !flush && (!full || idu_ready);
  assign ifu_valid_to_idu = !rst && !flush && (!empty || (BYPASS_EN && mem_valid));

  assign mem_fire = mem_valid && ifu_ready_to_mem;
  assign idu_fire = ifu_valid_to_idu && idu_ready;

  // An empty queue handing the incoming word straight through stores nothing.
  assign bypass_fire = BYPASS_EN && empty && mem_fire && idu_fire;
  assign wr_en       = mem_fire && !bypass_fire;
  assign rd_en       = idu_fire && !empty;

  // Head entry when something is stored, otherwise the live memory word.
  assign inst_ifu = (!empty || !BYPASS_EN) ? rd_entry[DATA_W-1:0] : imem_rdata;
  assign pc_ifu   = (!empty || !BYPASS_EN) ? rd_entry[EW-1:DATA_W] : imem_pc;

  ysyx_25040109_fifo_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({imem_pc, imem_rdata}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Pointer and occupancy bookkeeping; reset and flush empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/ysyx_25040109_ifu_queue.md
YSYX_25040109_IFU_QUEUE -- requirements
Module: ysyx_25040109_ifu_queue

Interface
REQ-001 Parameter DATA_W, default 32: instruction width in bits.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-003 Parameter BYPASS, default 1: 1 enables empty-queue pass-through, 0 gives a registered-only path.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 imem_rdata  input  DATA_W  fetched instruction from memory.
REQ-007 imem_pc  input  32  PC tag of imem_rdata.
REQ-008 mem_valid  input  1  upstream data valid.
REQ-009 ifu_ready_to_mem  output  1  queue can accept this cycle.
REQ-010 idu_ready  input  1  downstream can accept.
REQ-011 inst_ifu  output  DATA_W  instruction to IDU.
REQ-012 pc_ifu  output  32  PC tag paired with inst_ifu.
REQ-013 ifu_valid_to_idu  output  1  inst_ifu/pc_ifu valid.
REQ-014 flush  input  1  discard all held and in-flight entries (redirect).
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 mem_fire = mem_valid && ifu_ready_to_mem; idu_fire = ifu_valid_to_idu && idu_ready.
REQ-017 Storage: circular buffer; wr_ptr/rd_ptr of $clog2(DEPTH) bits wrap modulo DEPTH; count is an explicit counter of 0..DEPTH.
REQ-018 ifu_ready_to_mem = !flush && (count < DEPTH || idu_ready); accepting when full is legal only with a same-cycle dequeue.
REQ-019 ifu_valid_to_idu = !flush && (count != 0 || (BYPASS && mem_valid)).
REQ-020 When count != 0, inst_ifu/pc_ifu are taken from the rd_ptr entry; when count == 0 and BYPASS=1, they are imem_rdata/imem_pc combinationally.
REQ-021 Bypass fire (count==0, mem_fire, idu_fire): no write, pointers and count unchanged; zero-cycle latency.
REQ-022 BYPASS=0: data is written first and is visible to IDU the cycle after mem_fire; one-cycle minimum latency.
REQ-023 Count update: +1 on enqueue-only, -1 on dequeue-only, unchanged on both or neither; a non-bypass simultaneous enqueue and dequeue at count==DEPTH is valid and keeps count at DEPTH.
REQ-024 Ordering: strict FIFO; the dequeued {pc, inst} pair always matches the order of mem_fire.
REQ-025 Flush: in the flush cycle, valid and ready are forced to 0, no write occurs, and count, wr_ptr and rd_ptr are 0 next cycle; flush overrides every simultaneous event.
REQ-026 Outputs are undefined-but-ignored while ifu_valid_to_idu=0; no X propagates to valid, ready or count.
REQ-027 Once ifu_valid_to_idu=1 with count!=0, the presented entry is held stable until idu_fire or flush.

Reset
REQ-028 When rst is high at a clock edge, count, wr_ptr and rd_ptr are cleared to 0; storage contents are not reset.
REQ-029 While rst is asserted, ifu_valid_to_idu=0 and ifu_ready_to_mem=0; after release, ready=1 and valid=0 (or mem_valid when BYPASS=1).
REQ-030 A reset mid-operation discards all entries exactly as flush does.

Structure
REQ-031 A shared package ysyx_25040109_pkg holds XLEN=32 and IFQ_DEPTH_DEFAULT=4; the module parameters default to these values.
REQ-032 One sub-module, ysyx_25040109_fifo_ram (DEPTH x (DATA_W+32), 1 write port, 1 async read port, no reset), holds the storage.
REQ-033 Control logic (pointers, counter, handshakes) lives in the top module only.

Verification
REQ-034 Reset, then mem_valid=1 with imem_rdata=0x00000013, pc=0x80000000, idu_ready=1, BYPASS=1 -> same-cycle inst_ifu=0x00000013, valid=1, count stays 0.
REQ-035 idu_ready=0, push 4 words 0x11..0x44 -> count=4, ready=0 on the 5th cycle; then idu_ready=1 -> 0x11,0x22,0x33,0x44 drain in order, count reaches 0.
REQ-036 At count=4, mem_valid=1 with 0x55 and idu_ready=1 -> 0x11 dequeued, 0x55 enqueued, count=4, wr_ptr wraps to 1.
REQ-037 At count=3, flush=1 with mem_valid=1 -> valid=0, ready=0 that cycle; next cycle count=0 and 0x55 is never delivered.
REQ-038 BYPASS=0, empty queue, one push of 0xABCD0000 with idu_ready=1 -> valid=0 in cycle 0, valid=1 with 0xABCD0000 in cycle 1.
REQ-039 Random valid/ready toggling for 10k cycles with a scoreboard -> no loss, duplication or reordering, and count never exceeds DEPTH.
